// File: rtl/nf10_encap_input_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : nf10_encap_input_arbiter_pkg                                  |
// | Brief    : Shared constants and types for the encap input arbiter.       |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
package nf10_encap_input_arbiter_pkg;

  localparam int NUM_QUEUES = 4;
  localparam int QIDX_W     = 2;

  typedef logic [QIDX_W-1:0] qidx_t;

  // Arbiter state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/nf10_encap_input_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : nf10_encap_input_arbiter_if                                   |
// | Brief    : AXI4-Stream bundle with master/slave views.                   |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
interface nf10_encap_input_arbiter_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);
  import nf10_encap_input_arbiter_pkg::*;

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, output tstrb, output tuser, output tvalid,
                  output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tuser, input tvalid,
                  input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/fallthrough_small_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : fallthrough_small_fifo                                        |
// | Brief    : Small FIFO whose head entry is visible on dout without a      |
// |            read request; nearly_full asserts one entry before full.      |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             wr_en,
  input  wire logic             rd_en,
  output logic      [WIDTH-1:0] dout,
  output logic                  nearly_full,
  output logic                  empty
);
  localparam int MAX_DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] C_FULL   = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
  localparam logic [MAX_DEPTH_BITS:0] C_NEARLY = {1'b0, {MAX_DEPTH_BITS{1'b1}}};

  logic [WIDTH-1:0]          r_mem [MAX_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS:0]   r_depth;
  logic                      w_do_wr;
  logic                      w_do_rd;

  // Overflow and underflow requests are dropped rather than corrupting state
  assign w_do_wr     = wr_en & (r_depth != C_FULL);
  assign w_do_rd     = rd_en & (r_depth != '0);
  assign dout        = r_mem[r_rd_ptr];
  assign empty       = (r_depth == '0);
  assign nearly_full = (r_depth >= C_NEARLY);

  // Storage array; contents need no reset since depth gates visibility
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; simultaneous read and write both apply
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_depth  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_depth <= r_depth + 1'b1;
        2'b01:   r_depth <= r_depth - 1'b1;
        default: r_depth <= r_depth;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/nf10_encap_input_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : nf10_encap_input_arbiter                                      |
// | Brief    : Packet-granular round-robin merge of four AXI4-Stream ports   |
// |            into the encapsulator's single slave stream.                  |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module nf10_encap_input_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  wire logic axi_aclk,
  input  wire logic axi_resetn,
  nf10_encap_input_arbiter_if.slave  s_axis_0,
  nf10_encap_input_arbiter_if.slave  s_axis_1,
  nf10_encap_input_arbiter_if.slave  s_axis_2,
  nf10_encap_input_arbiter_if.slave  s_axis_3,
  nf10_encap_input_arbiter_if.master m_axis
);
  import nf10_encap_input_arbiter_pkg::*;

  // FIFO entry layout, LSB first: tdata, tstrb, tuser, tlast
  localparam int C_FIFO_WIDTH = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH
                              + C_S_AXIS_DATA_WIDTH/8 + 1;
  localparam int C_STRB_LSB   = C_M_AXIS_DATA_WIDTH;
  localparam int C_USER_LSB   = C_STRB_LSB + C_M_AXIS_DATA_WIDTH/8;
  localparam int C_LAST_BIT   = C_USER_LSB + C_M_AXIS_TUSER_WIDTH;

  logic [C_FIFO_WIDTH-1:0] w_fifo_din  [NUM_QUEUES];
  logic [C_FIFO_WIDTH-1:0] w_fifo_dout [NUM_QUEUES];
  logic [C_FIFO_WIDTH-1:0] w_head;
  logic [NUM_QUEUES-1:0]   w_in_valid;
  logic [NUM_QUEUES-1:0]   w_wr_en;
  logic [NUM_QUEUES-1:0]   w_rd_en;
  logic [NUM_QUEUES-1:0]   w_empty;
  logic [NUM_QUEUES-1:0]   w_nearly_full;
  logic                    w_fifo_reset;
  logic                    w_head_valid;
  logic                    w_head_last;
  logic [0:0]              r_state;
  qidx_t                   r_cur_queue;

  assign w_fifo_reset = ~axi_resetn;

  assign w_fifo_din[0] = {s_axis_0.tlast, s_axis_0.tuser, s_axis_0.tstrb, s_axis_0.tdata};
  assign w_fifo_din[1] = {s_axis_1.tlast, s_axis_1.tuser, s_axis_1.tstrb, s_axis_1.tdata};
  assign w_fifo_din[2] = {s_axis_2.tlast, s_axis_2.tuser, s_axis_2.tstrb, s_axis_2.tdata};
  assign w_fifo_din[3] = {s_axis_3.tlast, s_axis_3.tuser, s_axis_3.tstrb, s_axis_3.tdata};
  assign w_in_valid    = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};

  // Ingress ready depends only on FIFO occupancy, never on m_axis.tready
  assign s_axis_0.tready = ~w_nearly_full[0];
  assign s_axis_1.tready = ~w_nearly_full[1];
  assign s_axis_2.tready = ~w_nearly_full[2];
  assign s_axis_3.tready = ~w_nearly_full[3];

  generate
    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_fifo
      assign w_wr_en[gi] = w_in_valid[gi] & ~w_nearly_full[gi];

      fallthrough_small_fifo #(
        .WIDTH          (C_FIFO_WIDTH),
        .MAX_DEPTH_BITS (2)
      ) u_fifo (
        .clk         (axi_aclk),
        .reset       (w_fifo_reset),
        .din         (w_fifo_din[gi]),
        .wr_en       (w_wr_en[gi]),
        .rd_en       (w_rd_en[gi]),
        .dout        (w_fifo_dout[gi]),
        .nearly_full (w_nearly_full[gi]),
        .empty       (w_empty[gi])
      );
    end
  endgenerate

  // First non-empty queue after cur, wrapping through cur itself last.
  // Scanning farthest-to-nearest lets the nearest hit overwrite the others.
  function automatic qidx_t f_next_queue(input qidx_t cur,
                                         input logic [NUM_QUEUES-1:0] nonempty);
    qidx_t idx;
    f_next_queue = cur;
    for (int i = NUM_QUEUES; i >= 1; i--) begin
      idx = cur + qidx_t'(i);
      if (nonempty[idx]) f_next_queue = idx;
    end
  endfunction

  assign w_head       = w_fifo_dout[r_cur_queue];
  assign w_head_valid = (r_state == ST_PKT) & ~w_empty[r_cur_queue];
  assign w_head_last  = w_head[C_LAST_BIT];

  // Egress mux: zeros while idle, granted FIFO head while in a packet
  always_comb begin
    m_axis.tdata  = '0;
    m_axis.tstrb  = '0;
    m_axis.tuser  = '0;
    m_axis.tlast  = 1'b0;
    m_axis.tvalid = 1'b0;
    w_rd_en       = '0;
    if (r_state == ST_PKT) begin
      m_axis.tdata  = w_head[C_STRB_LSB-1:0];
      m_axis.tstrb  = w_head[C_USER_LSB-1:C_STRB_LSB];
      m_axis.tuser  = w_head[C_LAST_BIT-1:C_USER_LSB];
      m_axis.tlast  = w_head_last;
      m_axis.tvalid = w_head_valid;
      w_rd_en[r_cur_queue] = w_head_valid & m_axis.tready;
    end
  end

  // Grant FSM: pick a queue while idle, hold it until its tlast transfers
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      r_state     <= ST_IDLE;
      r_cur_queue <= qidx_t'(NUM_QUEUES - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|(~w_empty)) begin
            r_cur_queue <= f_next_queue(r_cur_queue, ~w_empty);
            r_state     <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (w_head_valid & m_axis.tready & w_head_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_nf10_encap_input_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : tb_nf10_encap_input_arbiter                                   |
// | Brief    : Directed vector bench for the encap input arbiter.            |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module tb_nf10_encap_input_arbiter;
  logic axi_aclk;
  logic axi_resetn;
  logic [3:0] w_sready;
  int n_vec;
  int n_err;

  nf10_encap_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s0 ();
  nf10_encap_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s1 ();
  nf10_encap_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s2 ();
  nf10_encap_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s3 ();
  nf10_encap_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) m ();

  nf10_encap_input_arbiter #(
    .C_M_AXIS_DATA_WIDTH(256), .C_S_AXIS_DATA_WIDTH(256),
    .C_M_AXIS_TUSER_WIDTH(128), .C_S_AXIS_TUSER_WIDTH(128)
  ) dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
    .s_axis_0(s0), .s_axis_1(s1), .s_axis_2(s2), .s_axis_3(s3), .m_axis(m)
  );

  assign w_sready = {s3.tready, s2.tready, s1.tready, s0.tready};

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  // Sideband fields derived from the data byte so they can be predicted
  function automatic logic [127:0] user_of(input logic [7:0] d);
    return {16{d}} ^ 128'h0123456789abcdeffedcba9876543210;
  endfunction
  function automatic logic [31:0] strb_of(input logic [7:0] d);
    return {24'h0, d ^ 8'hff};
  endfunction

  task automatic drive(input int p, input logic v, input logic l, input logic [7:0] d);
    case (p)
      0: begin s0.tvalid = v; s0.tlast = l; s0.tdata = 256'(d); s0.tuser = user_of(d); s0.tstrb = strb_of(d); end
      1: begin s1.tvalid = v; s1.tlast = l; s1.tdata = 256'(d); s1.tuser = user_of(d); s1.tstrb = strb_of(d); end
      2: begin s2.tvalid = v; s2.tlast = l; s2.tdata = 256'(d); s2.tuser = user_of(d); s2.tstrb = strb_of(d); end
      default: begin s3.tvalid = v; s3.tlast = l; s3.tdata = 256'(d); s3.tuser = user_of(d); s3.tstrb = strb_of(d); end
    endcase
  endtask

  task automatic idle_all();
    for (int p = 0; p < 4; p++) drive(p, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input logic [7:0] d, input logic l);
    chk({nm, "_valid"}, 256'(m.tvalid), 256'(1'b1));
    chk({nm, "_data"},  m.tdata, 256'(d));
    chk({nm, "_user"},  256'(m.tuser), 256'(user_of(d)));
    chk({nm, "_strb"},  256'(m.tstrb), 256'(strb_of(d)));
    chk({nm, "_last"},  256'(m.tlast), 256'(l));
  endtask

  task automatic next_cycle();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    m.tready   = 1'b1;
    axi_resetn = 1'b0;
    next_cycle();
    axi_resetn = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat;    // byte p is the data byte for port p
    logic        e_vld;
    logic        e_lst;
    logic [7:0]  e_dat;
  } vec_t;

  vec_t tbl [27];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int p = 0; p < 4; p++) drive(p, tbl[i].vld[p], tbl[i].lst[p], tbl[i].dat[8*p +: 8]);
      @(negedge axi_aclk);
      chk($sformatf("row%0d_sready", i), 256'(w_sready), 256'(4'hf));
      if (tbl[i].e_vld) chk_beat($sformatf("row%0d", i), tbl[i].e_dat, tbl[i].e_lst);
      else chk($sformatf("row%0d_valid", i), 256'(m.tvalid), 256'(1'b0));
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] bp_data [5];
    logic [3:0] seq0, seq3, exp0, exp3;
    logic       acc, acc0, acc3;
    int         src, rcv, ng;

    n_vec = 0;
    n_err = 0;

    // Simultaneous arrival on all ports: order 0,1,2,3 with idle gaps
    tbl[0]  = '{4'hf, 4'hf, 32'h13121110, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 8'h00};
    tbl[2]  = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 8'h10};
    tbl[3]  = '{4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 8'h00};
    tbl[4]  = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 8'h11};
    tbl[5]  = '{4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 8'h00};
    tbl[6]  = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 8'h12};
    tbl[7]  = '{4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 8'h00};
    tbl[8]  = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 8'h13};
    tbl[9]  = '{4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 8'h00};
    // Three-beat packet on port 2: first valid two cycles after first beat
    tbl[10] = '{4'h4, 4'h0, 32'h00a00000, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{4'h4, 4'h0, 32'h00a10000, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{4'h4, 4'h4, 32'h00a20000, 1'b1, 1'b0, 8'ha0};
    tbl[13] = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 8'ha1};
    tbl[14] = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 8'ha2};
    tbl[15] = '{4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 8'h00};
    // Port 0 stalls mid-packet while port 1 waits: grant must be held
    tbl[16] = '{4'h3, 4'h2, 32'h0000c0b0, 1'b0, 1'b0, 8'h00};
    tbl[17] = '{4'h1, 4'h0, 32'h000000b1, 1'b0, 1'b0, 8'h00};
    tbl[18] = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 8'hb0};
    tbl[19] = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 8'hb1};
    tbl[20] = '{4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 8'h00};
    tbl[21] = '{4'h1, 4'h0, 32'h000000b2, 1'b0, 1'b0, 8'h00};
    tbl[22] = '{4'h1, 4'h1, 32'h000000b3, 1'b1, 1'b0, 8'hb2};
    tbl[23] = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 8'hb3};
    tbl[24] = '{4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 8'h00};
    tbl[25] = '{4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 8'hc0};
    tbl[26] = '{4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 8'h00};

    idle_all();
    m.tready   = 1'b1;
    axi_resetn = 1'b0;
    repeat (2) @(posedge axi_aclk);
    #1;
    axi_resetn = 1'b1;

    // Reset state, first cycle after release
    @(negedge axi_aclk);
    chk("reset_tvalid", 256'(m.tvalid), 256'(1'b0));
    chk("reset_tlast",  256'(m.tlast),  256'(1'b0));
    chk("reset_tdata",  m.tdata,        256'(0));
    chk("reset_tuser",  256'(m.tuser),  256'(0));
    chk("reset_tstrb",  256'(m.tstrb),  256'(0));
    chk("reset_sready", 256'(w_sready), 256'(4'hf));
    next_cycle();

    run_rows(0, 15);

    // Ports 3 and 0 kept loaded with single-beat packets; grant was last on 2
    seq0 = '0; seq3 = '0; exp0 = '0; exp3 = '0; ng = 0;
    for (int cyc = 0; cyc < 44; cyc++) begin
      drive(0, 1'b1, 1'b1, {4'h0, seq0});
      drive(3, 1'b1, 1'b1, {4'h3, seq3});
      @(negedge axi_aclk);
      if (m.tvalid && m.tready) begin
        if (ng < 12)
          chk($sformatf("wrap_grant%0d_port", ng), 256'(m.tdata[7:4]),
              (ng % 2 == 0) ? 256'(3) : 256'(0));
        if (m.tdata[7:4] == 4'h3) begin
          chk_beat("wrap_p3", {4'h3, exp3}, 1'b1);
          exp3++;
        end else begin
          chk_beat("wrap_p0", {4'h0, exp0}, 1'b1);
          exp0++;
        end
        ng++;
      end
      acc0 = s0.tready;
      acc3 = s3.tready;
      next_cycle();
      if (acc0) seq0++;
      if (acc3) seq3++;
    end
    chk("wrap_grant_count", 256'(ng >= 16), 256'(1'b1));

    do_reset();
    run_rows(16, 26);

    // Backpressure: 5-beat packet on port 3, tready low for 5 cycles
    bp_data = '{8'hd0, 8'hd1, 8'hff, 8'hd3, 8'hd4};
    src = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      m.tready = !(cyc >= 2 && cyc < 7);
      if (src < 5) drive(3, 1'b1, src == 4, bp_data[src]);
      else drive(3, 1'b0, 1'b0, 8'h00);
      @(negedge axi_aclk);
      if (cyc == 3) chk("bp_sready_low", 256'(s3.tready), 256'(1'b0));
      if (cyc >= 2 && cyc < 7) chk_beat($sformatf("bp_hold%0d", cyc), bp_data[0], 1'b0);
      if (m.tvalid && m.tready) begin
        if (rcv < 5) chk_beat($sformatf("bp_beat%0d", rcv), bp_data[rcv], rcv == 4);
        else chk("bp_extra_beat", 256'(rcv), 256'(4));
        rcv++;
      end
      acc = s3.tready && (src < 5);
      next_cycle();
      if (acc) src++;
    end
    chk("bp_beat_count", 256'(rcv), 256'(5));
    m.tready = 1'b1;

    // Reset asserted during egress beat 2 of a 4-beat packet on port 0
    for (int c = 0; c < 4; c++) begin
      drive(0, 1'b1, c == 3, 8'he0 + 8'(c));
      if (c == 3) axi_resetn = 1'b0;
      @(negedge axi_aclk);
      if (c == 2) chk_beat("rst_beat1", 8'he0, 1'b0);
      if (c == 3) chk_beat("rst_beat2", 8'he1, 1'b0);
      next_cycle();
    end
    axi_resetn = 1'b1;
    idle_all();
    @(negedge axi_aclk);
    chk("rst_after_tvalid", 256'(m.tvalid), 256'(1'b0));
    chk("rst_after_tlast",  256'(m.tlast),  256'(1'b0));
    chk("rst_after_tdata",  m.tdata,        256'(0));
    chk("rst_after_sready", 256'(w_sready), 256'(4'hf));
    next_cycle();
    drive(1, 1'b1, 1'b0, 8'h51);
    @(negedge axi_aclk);
    chk("rst_flushed_c5", 256'(m.tvalid), 256'(1'b0));
    next_cycle();
    drive(1, 1'b1, 1'b1, 8'h52);
    @(negedge axi_aclk);
    chk("rst_flushed_c6", 256'(m.tvalid), 256'(1'b0));
    next_cycle();
    idle_all();
    @(negedge axi_aclk);
    chk_beat("rst_fresh0", 8'h51, 1'b0);
    next_cycle();
    @(negedge axi_aclk);
    chk_beat("rst_fresh1", 8'h52, 1'b1);
    next_cycle();
    @(negedge axi_aclk);
    chk("rst_fresh_done", 256'(m.tvalid), 256'(1'b0));
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/nf10_encap_input_arbiter.md
# nf10_encap_input_arbiter

Packet-granular round-robin arbiter that merges four AXI4-Stream ingress ports into the single slave stream of the encapsulation stage. Each ingress port is buffered in its own small fallthrough FIFO. The arbiter grants one whole packet at a time, so beats from different sources never interleave at the encapsulator input. It sits directly upstream of the encapsulator in the datapath.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master tdata width
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal C_M_AXIS_DATA_WIDTH
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal C_M_AXIS_TUSER_WIDTH
- axi_aclk  in  1  single clock for all logic
- axi_resetn  in  1  reset; synchronous, active-low
- s_axis_tdata_i (i=0..3)  in  C_S_AXIS_DATA_WIDTH  ingress data
- s_axis_tstrb_i  in  C_S_AXIS_DATA_WIDTH/8  ingress byte strobes
- s_axis_tuser_i  in  C_S_AXIS_TUSER_WIDTH  ingress metadata; passed through untouched
- s_axis_tvalid_i  in  1  ingress valid
- s_axis_tready_i  out  1  ingress ready
- s_axis_tlast_i  in  1  ingress end of packet
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  egress data to encapsulator
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  egress byte strobes
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  egress metadata
- m_axis_tvalid  out  1  egress valid
- m_axis_tready  in  1  egress ready
- m_axis_tlast  out  1  egress end of packet

## Operation
Ingress buffering:
- Each port has one FIFO, 4 entries deep.
- FIFO entry = {tlast, tuser, tstrb, tdata}.
- Write enable = s_axis_tvalid_i & ~nearly_full_i.
- s_axis_tready_i = ~nearly_full_i.

State machine (state register plus a 2-bit cur_queue register):
- IDLE:
  - All m_axis_* outputs are 0.
  - If any FIFO is non-empty, set cur_queue to the first non-empty queue, searching cur_queue+1, +2, +3, +0 (mod 4). Then go to PKT.
  - Otherwise stay in IDLE.
- PKT:
  - m_axis_tdata, m_axis_tstrb, m_axis_tuser and m_axis_tlast come combinationally from the head of FIFO[cur_queue].
  - m_axis_tvalid = ~empty[cur_queue].
  - rd_en[cur_queue] = m_axis_tvalid & m_axis_tready. All other FIFOs have rd_en = 0.
  - A beat with tvalid, tready and tlast all high goes to IDLE.
- Arithmetic: the search is modulo 4 on the 2-bit index and wraps naturally from 3 to 0.

Boundary conditions:
- Granted FIFO empties mid-packet: m_axis_tvalid drops and the grant is held. No other queue is served until that packet's tlast beat transfers.
- Backpressure: while tvalid=1 and tready=0, all m_axis_* outputs stay stable.
- Single-beat packet (tlast on the first beat): completes PKT in one transfer, then returns to IDLE.
- Simultaneous arrivals on all ports: served in strict rotation 0,1,2,3,0,…
- Write and read of the same FIFO in one cycle are both honoured.
- tstrb is not interpreted; zero-strobe beats pass through unchanged.
- Reset mid-packet:
  - All FIFOs are flushed, state goes to IDLE, cur_queue goes to 3.
  - The partial packet is truncated; no tlast is generated for it.

## Timing
- Reset values:
  - m_axis_tvalid = 0, m_axis_tlast = 0, and m_axis_tdata, m_axis_tstrb, m_axis_tuser = 0.
  - s_axis_tready_i = 1 in the first cycle after reset release.
  - cur_queue = 3, so port 0 has first priority.
- Latency from ingress beat to egress valid:
  - Idle arbiter: 2 cycles. Cycle 0 writes the FIFO; cycle 1 is IDLE and selects the queue; cycle 2 has m_axis_tvalid = 1.
  - Mid-packet, FIFO non-empty: 1 cycle (fallthrough output).
- Inter-packet gap: exactly one IDLE cycle between packets, even when another queue is waiting.
- Throughput: 1 beat/cycle within a packet when the FIFO is non-empty and tready is high.
- All outputs are combinational from registered state and FIFO heads. There is no path from m_axis_tready to s_axis_tready_i within a cycle.

## Structure
Shared package contents:
- NUM_QUEUES = 4.
- State encodings IDLE = 0, PKT = 1.
- Queue index width = 2.

Sub-modules and code organisation:
- Reuse the existing fallthrough_small_fifo: WIDTH = DATA + TUSER + DATA/8 + 1, MAX_DEPTH_BITS = 2. Instantiate it four times via generate.
- The round-robin next-queue search is a combinational function inside this module; no separate sub-module.

## Test plan
- Single port, back-to-back:
  - Stimulus: a 3-beat packet on port 2 (tdata = 0xA0, 0xA1, 0xA2), tready held at 1.
  - Required: egress shows the same 3 beats in order, tlast on beat 3, first tvalid 2 cycles after the first ingress beat, tuser unchanged.
- Simultaneous arrival:
  - Stimulus: a 1-beat packet on each of ports 0..3 in the same cycle.
  - Required: egress order 0,1,2,3, with one idle cycle between packets.
- No interleave:
  - Stimulus: port 0 sends 4 beats with a 3-cycle valid gap after beat 2; port 1 holds a pending packet.
  - Required: tvalid drops for the gap, and port 1 is not served until port 0's tlast beat transfers.
- Backpressure:
  - Stimulus: tready = 0 for 5 cycles mid-packet.
  - Required: outputs stay stable throughout; s_axis_tready_i drops once the FIFO holds 3 entries; no beat is lost or duplicated.
- Reset mid-packet:
  - Stimulus: assert axi_resetn = 0 for one cycle during beat 2 of a 4-beat packet.
  - Required: next cycle m_axis_tvalid = 0 and FIFOs are empty; a fresh packet on port 1 is then forwarded intact.
- Wrap-around fairness:
  - Stimulus: ports 3 and 0 are continuously loaded.
  - Required: grants alternate 3,0,3,0.
